// File: rtl/dicas_pkg.sv
// Shared definitions for the adivinhador password search: hint codes, FSM states
// and default widths. Used by adivinhador and passo_busca.
package dicas_pkg;

    localparam int LARG_A_PADRAO = 4;
    localparam int LARG_B_PADRAO = 3;

    localparam logic [1:0] COMP_MENOR  = 2'b00;
    localparam logic [1:0] COMP_MAIOR  = 2'b01;
    localparam logic [1:0] COMP_IGUAL  = 2'b10;
    localparam logic [1:0] COMP_ILEGAL = 2'b11;

    typedef enum logic [2:0] {
        OCIOSO,
        BUSCA_A,
        BUSCA_B,
        VERIFICA,
        FIM
    } estado_t;

    function automatic logic [3:0] incr_sat(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/passo_busca.sv
// One binary-search step: midpoint of [lo, hi] and the narrowed interval for a
// given hint, plus detection of illegal or contradictory hints.
module passo_busca
    import dicas_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_hi,
    input  logic [1:0]   i_comp,
    output logic [W-1:0] o_lo_next,
    output logic [W-1:0] o_hi_next,
    output logic [W-1:0] o_mid,
    output logic         o_erro
);

    localparam logic [W-1:0] UM = W'(1);

    // One extra bit keeps lo+hi from overflowing before the halving.
    logic [W:0] w_soma;

    assign w_soma = {1'b0, i_lo} + {1'b0, i_hi};
    assign o_mid  = w_soma[W:1];

    always_comb begin
        o_lo_next = i_lo;
        o_hi_next = i_hi;
        o_erro    = 1'b0;
        case (i_comp)
            COMP_MENOR: begin
                o_lo_next = o_mid + UM;
                o_erro    = (o_mid == i_hi);
            end
            COMP_MAIOR: begin
                o_hi_next = o_mid - UM;
                o_erro    = (o_mid == i_lo);
            end
            COMP_IGUAL: ;
            default:    o_erro = 1'b1;
        endcase
    end

endmodule

// File: rtl/adivinhador.sv
// Two-phase binary search guesser: finds senha A, then senha B, from hints on comp.
// Optional build macro CHECA_PARIDADE_EN adds a final parity check of the found pair.
module adivinhador
    import dicas_pkg::*;
#(
    parameter int LARG_A = LARG_A_PADRAO,
    parameter int LARG_B = LARG_B_PADRAO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        comp,
    input  logic              paridade,
    output logic [LARG_A-1:0] tentativaA,
    output logic [LARG_B-1:0] tentativaB,
    output logic              modoB,
    output logic              busy,
    output logic              done,
    output logic              erro,
    output logic [LARG_A-1:0] achadoA,
    output logic [LARG_B-1:0] achadoB,
    output logic [3:0]        num_tent
);

    estado_t r_estado, w_estado_next;

    logic [LARG_A-1:0] r_lo_a, r_hi_a, r_tent_a, r_achado_a;
    logic [LARG_B-1:0] r_lo_b, r_hi_b, r_tent_b, r_achado_b;
    logic              r_erro;
    logic [3:0]        r_num_tent;

    logic [LARG_A-1:0] w_lo_next_a, w_hi_next_a, w_mid_a;
    logic [LARG_B-1:0] w_lo_next_b, w_hi_next_b, w_mid_b;
    logic              w_erro_a, w_erro_b, w_erro_par;

    passo_busca #(.W(LARG_A)) u_passo_a (
        .i_lo      (r_lo_a),
        .i_hi      (r_hi_a),
        .i_comp    (comp),
        .o_lo_next (w_lo_next_a),
        .o_hi_next (w_hi_next_a),
        .o_mid     (w_mid_a),
        .o_erro    (w_erro_a)
    );

    passo_busca #(.W(LARG_B)) u_passo_b (
        .i_lo      (r_lo_b),
        .i_hi      (r_hi_b),
        .i_comp    (comp),
        .o_lo_next (w_lo_next_b),
        .o_hi_next (w_hi_next_b),
        .o_mid     (w_mid_b),
        .o_erro    (w_erro_b)
    );

`ifdef CHECA_PARIDADE_EN
    assign w_erro_par = ((^r_achado_a) ^ (^r_achado_b)) != paridade;
`else
    // Parity hint is deliberately ignored in this build.
    assign w_erro_par = paridade & 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    always_comb begin
        w_estado_next = r_estado;
        busy          = 1'b0;
        done          = 1'b0;
        modoB         = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (start) w_estado_next = BUSCA_A;
            end
            BUSCA_A: begin
                busy = 1'b1;
                if (w_erro_a)                 w_estado_next = FIM;
                else if (comp == COMP_IGUAL)  w_estado_next = BUSCA_B;
            end
            BUSCA_B: begin
                busy  = 1'b1;
                modoB = 1'b1;
                if (w_erro_b)                 w_estado_next = FIM;
                else if (comp == COMP_IGUAL)  w_estado_next = VERIFICA;
            end
            VERIFICA: begin
                busy          = 1'b1;
                modoB         = 1'b1;
                w_estado_next = FIM;
            end
            FIM: begin
                done          = 1'b1;
                w_estado_next = OCIOSO;
            end
            default: w_estado_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo_a     <= '0;
            r_hi_a     <= '0;
            r_lo_b     <= '0;
            r_hi_b     <= '0;
            r_tent_a   <= '0;
            r_tent_b   <= '0;
            r_achado_a <= '0;
            r_achado_b <= '0;
            r_erro     <= 1'b0;
            r_num_tent <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (start) begin
                        r_lo_a     <= '0;
                        r_hi_a     <= '1;
                        r_achado_a <= '0;
                        r_achado_b <= '0;
                        r_erro     <= 1'b0;
                        r_num_tent <= '0;
                    end
                end
                BUSCA_A: begin
                    r_num_tent <= incr_sat(r_num_tent);
                    r_tent_a   <= w_mid_a;
                    r_lo_a     <= w_lo_next_a;
                    r_hi_a     <= w_hi_next_a;
                    if (w_erro_a) begin
                        r_erro <= 1'b1;
                    end else if (comp == COMP_IGUAL) begin
                        r_achado_a <= w_mid_a;
                        r_lo_b     <= '0;
                        r_hi_b     <= '1;
                    end
                end
                BUSCA_B: begin
                    r_num_tent <= incr_sat(r_num_tent);
                    r_tent_b   <= w_mid_b;
                    r_lo_b     <= w_lo_next_b;
                    r_hi_b     <= w_hi_next_b;
                    if (w_erro_b)                r_erro     <= 1'b1;
                    else if (comp == COMP_IGUAL) r_achado_b <= w_mid_b;
                end
                VERIFICA: begin
                    r_erro <= r_erro | w_erro_par;
                end
                default: ;
            endcase
        end
    end

    // The active phase shows the live midpoint; the other holds its last guess.
    assign tentativaA = (r_estado == BUSCA_A) ? w_mid_a : r_tent_a;
    assign tentativaB = (r_estado == BUSCA_B) ? w_mid_b : r_tent_b;
    assign erro       = r_erro;
    assign achadoA    = r_achado_a;
    assign achadoB    = r_achado_b;
    assign num_tent   = r_num_tent;

endmodule

// File: tb/tb_adivinhador.sv
// Directed bench for adivinhador: a hint oracle answers each guess from the
// chosen passwords; expected guess sequences and results are hand-computed.
module tb_adivinhador;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] comp;
    logic       paridade;
    logic [3:0] tentativaA;
    logic [2:0] tentativaB;
    logic       modoB, busy, done, erro;
    logic [3:0] achadoA;
    logic [2:0] achadoB;
    logic [3:0] num_tent;

    int checks = 0;
    int errors = 0;

    int senha_a, senha_b;
    bit force_ilegal;
    int exp_a[$];
    int exp_b[$];

    adivinhador dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .comp       (comp),
        .paridade   (paridade),
        .tentativaA (tentativaA),
        .tentativaB (tentativaB),
        .modoB      (modoB),
        .busy       (busy),
        .done       (done),
        .erro       (erro),
        .achadoA    (achadoA),
        .achadoB    (achadoB),
        .num_tent   (num_tent)
    );

    always #5 clk = ~clk;

    always_comb begin
        int g;
        g = modoB ? int'(tentativaB) : int'(tentativaA);
        if (force_ilegal)     comp = 2'b11;
        else if (g < (modoB ? senha_b : senha_a)) comp = 2'b00;
        else if (g > (modoB ? senha_b : senha_a)) comp = 2'b01;
        else                  comp = 2'b10;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".tentativaA"}, 32'(tentativaA), 0);
        chk({tag, ".tentativaB"}, 32'(tentativaB), 0);
        chk({tag, ".modoB"},      32'(modoB),      0);
        chk({tag, ".busy"},       32'(busy),       0);
        chk({tag, ".done"},       32'(done),       0);
        chk({tag, ".erro"},       32'(erro),       0);
        chk({tag, ".achadoA"},    32'(achadoA),    0);
        chk({tag, ".achadoB"},    32'(achadoB),    0);
        chk({tag, ".num_tent"},   32'(num_tent),   0);
    endtask

    // Starts a search (called at a falling edge) and checks every guess and result.
    task automatic run_busca(input string tag, input int sa, input int sb,
                             input int n_exp, input int erro_exp);
        int ia = 0;
        int ib = 0;
        int c  = 0;
        senha_a = sa;
        senha_b = sb;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk({tag, ".busy_after_start"}, 32'(busy), 1);
        while (done !== 1'b1 && c < 30) begin
            if (busy === 1'b1 && modoB === 1'b0) begin
                if (ia < exp_a.size())
                    chk($sformatf("%s.guessA%0d", tag, ia), 32'(tentativaA), exp_a[ia]);
                ia++;
            end else if (busy === 1'b1 && modoB === 1'b1) begin
                if (ib < exp_b.size())
                    chk($sformatf("%s.guessB%0d", tag, ib), 32'(tentativaB), exp_b[ib]);
                ib++;
            end
            @(negedge clk);
            c++;
        end
        chk({tag, ".done_seen"},   32'(done), 1);
        chk({tag, ".countA"},      ia, exp_a.size());
        chk({tag, ".countB"},      ib, exp_b.size() + 1);
        chk({tag, ".busy_at_done"}, 32'(busy), 0);
        chk({tag, ".modoB_at_done"}, 32'(modoB), 0);
        chk({tag, ".achadoA"},     32'(achadoA), sa);
        chk({tag, ".achadoB"},     32'(achadoB), sb);
        chk({tag, ".num_tent"},    32'(num_tent), n_exp);
        chk({tag, ".erro"},        32'(erro), erro_exp);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, 32'(done), 0);
        $display("search %s: senhaA=%0d senhaB=%0d achadoA=%0d achadoB=%0d num_tent=%0d erro=%0d",
                 tag, sa, sb, achadoA, achadoB, num_tent, erro);
    endtask

    initial begin
        int c;
        rst          = 1'b1;
        start        = 1'b0;
        paridade     = 1'b0;
        force_ilegal = 1'b0;
        senha_a      = 0;
        senha_b      = 0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        exp_a = '{7, 11, 9};        exp_b = '{3, 5};
        run_busca("s9_5", 9, 5, 5, 0);

        exp_a = '{7, 11, 13, 14, 15}; exp_b = '{3, 5, 6, 7};
        run_busca("s15_7", 15, 7, 9, 0);

        exp_a = '{7, 3, 1, 0};      exp_b = '{3, 1, 0};
        run_busca("s0_0", 0, 0, 7, 0);

        // Illegal hint on the very first guess, with a start retried while busy.
        force_ilegal = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("ilegal.first_guess", 32'(tentativaA), 7);
        chk("ilegal.busy", 32'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        chk("ilegal.done", 32'(done), 1);
        chk("ilegal.erro", 32'(erro), 1);
        chk("ilegal.num_tent", 32'(num_tent), 1);
        chk("ilegal.busy_at_done", 32'(busy), 0);
        @(negedge clk);
        chk("ilegal.done_one_cycle", 32'(done), 0);
        chk("ilegal.start_ignored", 32'(busy), 0);
        chk("ilegal.erro_held", 32'(erro), 1);
        force_ilegal = 1'b0;
        $display("ilegal hint: erro=%0d num_tent=%0d", erro, num_tent);
        @(negedge clk);

        // Reset asserted mid-search while in the B phase.
        senha_a = 9;
        senha_b = 5;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        c = 0;
        while (modoB !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("midrst.reached_B", 32'(modoB), 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset during BUSCA_B applied");
        exp_a = '{7, 11, 9};        exp_b = '{3, 5};
        run_busca("rerun9_5", 9, 5, 5, 0);

`ifdef CHECA_PARIDADE_EN
        paridade = 1'b1;
        run_busca("par1", 9, 5, 5, 1);
        paridade = 1'b0;
        run_busca("par0", 9, 5, 5, 0);
`else
        paridade = 1'b1;
        run_busca("par_ignored", 9, 5, 5, 0);
        paridade = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
